// File: rtl/full_adder_pkg.sv
// Shared constants and result type for the full_adder block.
package full_adder_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  // Raw adder result: carry-out on top of the widest supported sum field.
  typedef struct packed {
    logic                    cout;
    logic [FA_MAX_WIDTH-1:0] sum;
  } fa_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full-adder cell; chained ci->co by the top level.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a single registered output stage.
// Optional macro FULL_ADDER_OVERFLOW_EN adds a registered signed-overflow
// flag on port ovf.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  fa_result_t       res;
  fa_result_t       res_q;
  logic             valid_q;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Pack the ripple result into the shared result type (upper sum bits zero).
  always_comb begin
    res                  = '0;
    res.cout             = c[WIDTH];
    res.sum[WIDTH-1:0]   = s;
  end

  // Output register: loads only on in_valid so idle inputs never leak through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res;
      end
    end
  end

  assign out_valid = valid_q;
  assign sum       = res_q.sum[WIDTH-1:0];
  assign cout      = res_q.cout;
  // Decoded from the registered sum; unused upper bits are constant zero.
  assign zero      = (res_q.sum == '0);

`ifdef FULL_ADDER_OVERFLOW_EN
  logic ovf_q;

  // Signed overflow flag, same load rule as the sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder: WIDTH=8 and WIDTH=1 instances side by side.
module tb_full_adder;

  typedef struct {
    longint sum;
    logic   cout;
    logic   zero;
    logic   ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [0:0] a1, b1;
  logic       cin1;

  logic       ov8, ov1;
  logic [7:0] sum8;
  logic [0:0] sum1;
  logic       cout8, cout1, zero8, zero1;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic       ovf8, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  exp_t q8[$];
  exp_t q1[$];
  exp_t held8, held1;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(sum8), .cout(cout8), .zero(zero8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .ovf(ovf8)
`endif
  );

  full_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(sum1), .cout(cout1), .zero(zero1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .ovf(ovf1)
`endif
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(int w, longint x, longint y, longint ci);
    exp_t   e;
    longint m    = longint'(1) <<< w;
    longint full = x + y + ci;
    longint sx   = (x >= m / 2) ? x - m : x;
    longint sy   = (y >= m / 2) ? y - m : y;
    longint sr   = sx + sy + ci;
    e.sum  = full % m;
    e.cout = (full >= m);
    e.zero = (e.sum == 0);
    e.ovf  = (sr > m / 2 - 1) || (sr < -(m / 2));
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.sum = 0; e.cout = 1'b0; e.zero = 1'b1; e.ovf = 1'b0;
    return e;
  endfunction

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on out_valid, otherwise outputs must hold the last result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (ov8) begin
          if (q8.size() == 0) cmp("w8_unexpected_valid", 1, 0);
          else begin
            e = q8.pop_front();
            cmp("w8_sum", sum8, e.sum);
            cmp("w8_cout", cout8, e.cout);
            cmp("w8_zero", zero8, e.zero);
`ifdef FULL_ADDER_OVERFLOW_EN
            cmp("w8_ovf", ovf8, e.ovf);
`endif
            held8 = e;
          end
        end else begin
          cmp("w8_hold_sum", sum8, held8.sum);
          cmp("w8_hold_cout", cout8, held8.cout);
          cmp("w8_hold_zero", zero8, held8.zero);
        end
        if (ov1) begin
          if (q1.size() == 0) cmp("w1_unexpected_valid", 1, 0);
          else begin
            e = q1.pop_front();
            cmp("w1_sum", sum1, e.sum);
            cmp("w1_cout", cout1, e.cout);
            cmp("w1_zero", zero1, e.zero);
`ifdef FULL_ADDER_OVERFLOW_EN
            cmp("w1_ovf", ovf1, e.ovf);
`endif
            held1 = e;
          end
        end else begin
          cmp("w1_hold_sum", sum1, held1.sum);
          cmp("w1_hold_cout", cout1, held1.cout);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] x8, input logic [7:0] y8,
                       input bit c8, input bit x1, input bit y1, input bit c1);
    @(negedge clk);
    in_valid = v;
    a8 = x8; b8 = y8; cin8 = c8;
    a1 = x1; b1 = y1; cin1 = c1;
    if (v) begin
      q8.push_back(model(8, longint'(x8), longint'(y8), longint'(c8)));
      q1.push_back(model(1, longint'(x1), longint'(y1), longint'(c1)));
    end
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, "_ov8"}, ov8, 0);
    cmp({tag, "_sum8"}, sum8, 0);
    cmp({tag, "_cout8"}, cout8, 0);
    cmp({tag, "_zero8"}, zero8, 1);
    cmp({tag, "_ov1"}, ov1, 0);
    cmp({tag, "_zero1"}, zero1, 1);
`ifdef FULL_ADDER_OVERFLOW_EN
    cmp({tag, "_ovf8"}, ovf8, 0);
`endif
  endtask

  initial begin
    logic [2:0] v3;
    held8 = reset_exp();
    held1 = reset_exp();
    rst_n = 1'b0; in_valid = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #3;
    check_reset("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table, one vector per cycle.
    for (int unsigned i = 0; i < 8; i++) begin
      v3 = 3'(i);
      drive(1'b1, 8'(i), 8'(i * 3), 1'b0, v3[2], v3[1], v3[0]);
    end

    // WIDTH=8 boundaries.
    drive(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);

    // Hold: one valid add then idle cycles with random operands.
    drive(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++)
      drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));

    // Back-to-back.
    drive(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);

    // Mid-stream asynchronous reset drops the in-flight result.
    drive(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    q8.delete();
    q1.delete();
    held8 = reset_exp();
    held1 = reset_exp();
    check_reset("rst_async");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Randomised traffic with random idle gaps.
    for (int unsigned i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));

    for (int unsigned i = 0; i < 3; i++)
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("w8_drain", q8.size(), 0);
    cmp("w1_drain", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
